adder_arbiter: RTL and testbench
================================

# adder_arbiter

Round-robin arbiter that shares one 32-bit adder instance among up to four requesters, such as PC+4, branch-target and address-generation paths in a multi-cycle or pipelined core. Each requester presents operands with a valid/ready handshake. The arbiter grants one requester per cycle, computes the sum through the existing `adder` module and stores the result in a single-entry output register, tagged with the requester ID. The output register drains through its own valid/ready handshake, so the adder is never occupied beyond one cycle per grant.

## Interface
- `NUM_REQ`, default 4: number of requesters. Legal range is 2..4. `rsp_id` is 2 bits wide regardless of this value.
- `WIDTH`, default 32: operand and sum width.

Ports (name, direction, width, meaning):
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  bit i set: requester i has operands pending.
- `req_ready`  out  NUM_REQ  one-hot or zero; bit i set: requester i is granted this cycle.
- `req_a`  in  NUM_REQ*WIDTH  operand A; requester i uses `[i*WIDTH +: WIDTH]`.
- `req_b`  in  NUM_REQ*WIDTH  operand B; same packing as `req_a`.
- `rsp_valid`  out  1  result register holds an undelivered result.
- `rsp_ready`  in  1  consumer accepts the result this cycle.
- `rsp_id`  out  2  index of the requester that produced the result.
- `rsp_sum`  out  WIDTH  `(a + b) mod 2^WIDTH`.
- `rsp_carry`  out  1  carry-out, i.e. bit WIDTH of the `WIDTH+1`-bit sum.

## Operation
- **State:**
  - round-robin pointer `ptr` (2 bits);
  - result register {`rsp_valid`, `rsp_id`, `rsp_sum`, `rsp_carry`}.
- **Slot availability:** `can_accept = !rsp_valid || rsp_ready`.
- **Arbitration:**
  - Search `req_valid` starting at index `ptr`, then ptr+1, and so on, wrapping modulo NUM_REQ.
  - The first set bit is `g`.
  - If `can_accept` and any valid bit is set, assert `req_ready[g]` only. Otherwise `req_ready = 0`.
- **Combinational path:**
  - `req_ready` depends combinationally on `req_valid`, `rsp_valid` and `rsp_ready`.
  - Requesters must not derive `req_valid` from `req_ready`.
- **Datapath:**
  - The muxed operands `req_a[g]` and `req_b[g]` feed a single `adder` instance for `rsp_sum`.
  - Carry comes from a `WIDTH+1`-bit add of the same operands.
- **On grant (rising edge):**
  - `rsp_valid ← 1`, `rsp_id ← g`, `rsp_sum ← sum`, `rsp_carry ← carry`.
  - `ptr ← (g+1) mod NUM_REQ`.
- **No grant, `rsp_valid && rsp_ready`:** `rsp_valid ← 0`. The data fields hold their last value.
- **No grant, `rsp_valid && !rsp_ready`:** all result fields are held stable, bit-exact.
- **Simultaneous drain and grant:** the new result replaces the old in the same edge, and `rsp_valid` stays 1.
- **Pointer:** changes only on a grant. Idle cycles do not move it.
- **Reset, asynchronous on `rst_n` low:**
  - `ptr = 0`, `rsp_valid = 0`, `rsp_id = 0`, `rsp_sum = 0`, `rsp_carry = 0`.
  - `req_ready` is forced to 0 while `rst_n` is low.
  - Any pending result is discarded, with no partial delivery.
- **Requester bits at or above NUM_REQ:** not present; the ID space is 0..NUM_REQ-1.

## Timing
- **Latency:** a grant at edge T produces `rsp_valid = 1` with its result after edge T, i.e. during cycle T+1.
- **Throughput:** one result per cycle while `rsp_ready` is held at 1.
- **Fairness:** a requester holding `req_valid` continuously is granted within NUM_REQ grant cycles, with at most NUM_REQ-1 other grants before it.
- **Backpressure:** while `rsp_valid && !rsp_ready`, `req_ready = 0` and requester operands are not sampled.
- **Reset release:**
  - The first grant is possible on the first rising edge with `rst_n` high.
  - Priority starts at requester 0.

## Test plan
- **Reset:** `rst_n = 0` with all `req_valid = 1` → `req_ready = 0`, `rsp_valid = 0`, `rsp_id = 0`, `rsp_sum = 0`, `rsp_carry = 0`.
- **Single request:** requester 0 with a=5, b=9, `rsp_ready = 1` → next cycle `rsp_valid = 1`, `rsp_id = 0`, `rsp_sum = 14`, `rsp_carry = 0`. With no further requests, `rsp_valid = 0` one cycle later.
- **Overflow:** requester 2 with a=0xFFFFFFFF, b=0x00000001 → `rsp_id = 2`, `rsp_sum = 0`, `rsp_carry = 1`.
- **Round-robin:** all four requesters continuously valid with distinct operands (requester i: a=i, b=0x10), `rsp_ready = 1` → results in order of `rsp_id` 0,1,2,3,0 on consecutive cycles, with sums 0x10, 0x11, 0x12, 0x13, 0x10.
- **Backpressure:**
  - Requester 1 sends a=0x11, b=0x22, then `rsp_ready = 0` for 3 cycles with requester 3 valid → result 0x33/id 1 held stable and `req_ready = 0` throughout.
  - Raising `rsp_ready` grants requester 3 in the same cycle; its result appears the next cycle.
- **Mid-operation reset:** `rst_n` is pulsed low while `rsp_valid = 1` and `ptr = 2` → `rsp_valid` drops immediately, without waiting for a clock edge. After release, requesters 0 and 2 are both valid and requester 0 is granted first.

Source files
------------

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one adder among up to four requesters.
// The winning requester's operands pass through the adder. The result
// is captured in a single-entry output register tagged with the
// requester ID, and it drains through its own valid/ready handshake.

// Plain combinational adder; the sum wraps modulo 2^WIDTH.
module adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  assign sum = a + b;

endmodule

module adder_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [1:0]               rsp_id,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_carry
);

  logic [1:0]       r_ptr;
  logic             r_rspValid;
  logic [1:0]       r_rspId;
  logic [WIDTH-1:0] r_rspSum;
  logic             r_rspCarry;

  logic             w_found;
  logic [1:0]       w_grantIdx;
  logic             w_canAccept;
  logic             w_grant;
  logic [1:0]       w_nextPtr;
  logic [WIDTH-1:0] w_opA;
  logic [WIDTH-1:0] w_opB;
  logic [WIDTH-1:0] w_sum;
  logic             w_carry;

  // The output slot can take a new result when it is empty or draining this cycle.
  assign w_canAccept = !r_rspValid || rsp_ready;

  // Scan requesters starting at the pointer, wrapping; the first valid one wins.
  always_comb begin
    w_found    = 1'b0;
    w_grantIdx = 2'd0;
    for (int k = 0; k < NUM_REQ; k++) begin : scan
      int idx;
      idx = (int'(r_ptr) + k) % NUM_REQ;
      if (!w_found && req_valid[idx]) begin
        w_found    = 1'b1;
        w_grantIdx = 2'(idx);
      end
    end
  end

  // A grant needs a winner and room in the output slot. It is suppressed during reset.
  assign w_grant   = w_found && w_canAccept && rst_n;
  assign w_nextPtr = 2'((int'(w_grantIdx) + 1) % NUM_REQ);

  // One-hot ready toward the granted requester, or all zero.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = w_grant && (w_grantIdx == 2'(i));
    end
  end

  // Select the winner's operands for the shared adder.
  always_comb begin
    w_opA = '0;
    w_opB = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grantIdx == 2'(i)) begin
        w_opA = req_a[i*WIDTH +: WIDTH];
        w_opB = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  adder #(
    .WIDTH(WIDTH)
  ) u_adder (
    .a  (w_opA),
    .b  (w_opB),
    .sum(w_sum)
  );

  // Carry-out is the top bit of a one-bit-wider add of the same operands.
  assign w_carry = 1'(({1'b0, w_opA} + {1'b0, w_opB}) >> WIDTH);

  // Load the result register on a grant. Otherwise clear valid when it drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr      <= 2'd0;
      r_rspValid <= 1'b0;
      r_rspId    <= 2'd0;
      r_rspSum   <= '0;
      r_rspCarry <= 1'b0;
    end else if (w_grant) begin
      r_ptr      <= w_nextPtr;
      r_rspValid <= 1'b1;
      r_rspId    <= w_grantIdx;
      r_rspSum   <= w_sum;
      r_rspCarry <= w_carry;
    end else if (r_rspValid && rsp_ready) begin
      r_rspValid <= 1'b0;
    end
  end

  assign rsp_valid = r_rspValid;
  assign rsp_id    = r_rspId;
  assign rsp_sum   = r_rspSum;
  assign rsp_carry = r_rspCarry;

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter.
// Stimulus pushes the hand-computed results onto a queue.
// A negedge monitor pops and compares each result the DUT delivers.
module tb_adder_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 32;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] sum;
    logic        carry;
  } rsp_t;

  logic                     clk;
  logic                     rst_n;
  logic [NUM_REQ-1:0]       reqValid;
  logic [NUM_REQ-1:0]       reqReady;
  logic [NUM_REQ*WIDTH-1:0] reqA;
  logic [NUM_REQ*WIDTH-1:0] reqB;
  logic                     rspValid;
  logic                     rspReady;
  logic [1:0]               rspId;
  logic [WIDTH-1:0]         rspSum;
  logic                     rspCarry;

  rsp_t expQ[$];
  int   checks    = 0;
  int   errors    = 0;
  int   pushed    = 0;
  int   delivered = 0;

  adder_arbiter #(
    .NUM_REQ(NUM_REQ),
    .WIDTH  (WIDTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(reqValid),
    .req_ready(reqReady),
    .req_a    (reqA),
    .req_b    (reqB),
    .rsp_valid(rspValid),
    .rsp_ready(rspReady),
    .rsp_id   (rspId),
    .rsp_sum  (rspSum),
    .rsp_carry(rspCarry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic [31:0] a, input logic [31:0] b);
    reqA[idx*WIDTH +: WIDTH] = a;
    reqB[idx*WIDTH +: WIDTH] = b;
  endtask

  task automatic expectRsp(input logic [1:0] id, input logic [31:0] sum, input logic carry);
    rsp_t r;
    r.id    = id;
    r.sum   = sum;
    r.carry = carry;
    expQ.push_back(r);
    pushed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check every delivered result against the queue, in the order it was issued.
  always @(negedge clk) begin
    if (rst_n && rspValid && rspReady) begin
      rsp_t e;
      delivered++;
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_rsp: got id %0d sum 0x%0h, expected no result", rspId, rspSum);
      end else begin
        e = expQ.pop_front();
        checkOutput("rsp_id", 64'(rspId), 64'(e.id));
        checkOutput("rsp_sum", 64'(rspSum), 64'(e.sum));
        checkOutput("rsp_carry", 64'(rspCarry), 64'(e.carry));
      end
    end
  end

  initial begin
    rst_n    = 1'b1;
    reqValid = '0;
    reqA     = '0;
    reqB     = '0;
    rspReady = 1'b1;
    #1;
    // Reset holds everything at zero, even with all requesters valid.
    rst_n    = 1'b0;
    reqValid = 4'hF;
    #2;
    checkOutput("reset_req_ready", 64'(reqReady), 64'h0);
    checkOutput("reset_rsp_valid", 64'(rspValid), 64'h0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_req_ready_edge", 64'(reqReady), 64'h0);
    checkOutput("reset_rsp_valid_edge", 64'(rspValid), 64'h0);
    checkOutput("reset_rsp_id", 64'(rspId), 64'h0);
    checkOutput("reset_rsp_sum", 64'(rspSum), 64'h0);
    checkOutput("reset_rsp_carry", 64'(rspCarry), 64'h0);
    reqValid = '0;
    #2;
    rst_n = 1'b1;

    // Single request from requester 0: 5 + 9 = 14.
    applyStimulus(0, 32'd5, 32'd9);
    reqValid = 4'b0001;
    #1;
    checkOutput("single_req_ready", 64'(reqReady), 64'h1);
    expectRsp(2'd0, 32'd14, 1'b0);
    tick();
    reqValid = '0;
    checkOutput("single_rsp_valid", 64'(rspValid), 64'h1);
    tick();
    checkOutput("single_rsp_drained", 64'(rspValid), 64'h0);

    // Overflow on requester 2 (pointer is now 1).
    applyStimulus(2, 32'hFFFF_FFFF, 32'h0000_0001);
    reqValid = 4'b0100;
    #1;
    checkOutput("ovf_req_ready", 64'(reqReady), 64'h4);
    expectRsp(2'd2, 32'h0, 1'b1);
    tick();
    reqValid = '0;
    tick();

    // Requester 3 moves the pointer back to 0.
    applyStimulus(3, 32'h100, 32'h200);
    reqValid = 4'b1000;
    #1;
    checkOutput("wrap_req_ready", 64'(reqReady), 64'h8);
    expectRsp(2'd3, 32'h300, 1'b0);
    tick();
    reqValid = '0;
    tick();

    // Round-robin with all four requesters continuously valid.
    for (int i = 0; i < 4; i++) applyStimulus(i, 32'(i), 32'h10);
    reqValid = 4'hF;
    for (int n = 0; n < 5; n++) begin
      #1;
      checkOutput($sformatf("rr_req_ready_%0d", n), 64'(reqReady), 64'(1 << (n % 4)));
      expectRsp(2'(n % 4), 32'h10 + 32'(n % 4), 1'b0);
      tick();
    end
    reqValid = '0;
    tick();

    // Backpressure: result from requester 1 is held while requester 3 waits.
    applyStimulus(1, 32'h11, 32'h22);
    reqValid = 4'b0010;
    #1;
    checkOutput("bp_req_ready_r1", 64'(reqReady), 64'h2);
    expectRsp(2'd1, 32'h33, 1'b0);
    tick();
    applyStimulus(3, 32'h40, 32'h2);
    reqValid = 4'b1000;
    rspReady = 1'b0;
    for (int n = 0; n < 3; n++) begin
      #1;
      checkOutput($sformatf("bp_req_ready_%0d", n), 64'(reqReady), 64'h0);
      checkOutput($sformatf("bp_rsp_valid_%0d", n), 64'(rspValid), 64'h1);
      checkOutput($sformatf("bp_rsp_sum_%0d", n), 64'(rspSum), 64'h33);
      checkOutput($sformatf("bp_rsp_id_%0d", n), 64'(rspId), 64'h1);
      tick();
    end
    rspReady = 1'b1;
    #1;
    checkOutput("bp_release_req_ready", 64'(reqReady), 64'h8);
    expectRsp(2'd3, 32'h42, 1'b0);
    tick();
    reqValid = '0;
    tick();

    // Put the pointer at 2, then leave an undelivered result pending.
    applyStimulus(1, 32'd1, 32'd1);
    reqValid = 4'b0010;
    expectRsp(2'd1, 32'd2, 1'b0);
    tick();
    reqValid = '0;
    tick();
    rspReady = 1'b0;
    applyStimulus(1, 32'd7, 32'd8);
    reqValid = 4'b0010;
    tick();
    reqValid = '0;
    checkOutput("mid_pending_valid", 64'(rspValid), 64'h1);
    #2;
    rst_n = 1'b0;
    reqValid = 4'b0101;
    #1;
    checkOutput("mid_reset_rsp_valid", 64'(rspValid), 64'h0);
    checkOutput("mid_reset_req_ready", 64'(reqReady), 64'h0);
    #2;
    rst_n    = 1'b1;
    rspReady = 1'b1;
    applyStimulus(0, 32'd3, 32'd4);
    applyStimulus(2, 32'h20, 32'h30);
    #1;
    checkOutput("post_reset_first", 64'(reqReady), 64'h1);
    expectRsp(2'd0, 32'd7, 1'b0);
    tick();
    checkOutput("post_reset_second", 64'(reqReady), 64'h4);
    expectRsp(2'd2, 32'h50, 1'b0);
    tick();
    reqValid = '0;
    repeat (3) tick();

    checkOutput("queue_empty", 64'(expQ.size()), 64'h0);
    checkOutput("delivered_count", 64'(delivered), 64'(pushed));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
